vram_scanout_reader: RTL

- Read-side master for the single-port-read / single-port-write byte VRAM.
- Walks the frame buffer in raster order and drives the VRAM read port (1-clk registered read latency).
- Packs three consecutive bytes into one 24-bit RGB pixel and presents it on a valid/ready pixel stream with start-of-frame and end-of-line markers for the display/output pipeline.

---
 rtl/vram_scanout_reader.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_scanout_reader.sv
// -----------------------------------------------------------------------------
// vram_scanout_reader
//
// Read-side master for the byte-wide frame-buffer VRAM. Walks the frame in
// raster order, issues one byte read per cycle (the VRAM has a 1-clk registered
// read latency), packs three consecutive bytes into a 24-bit RGB pixel and
// presents it on a valid/ready pixel stream.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   run                 level, high = scan frames continuously
//   vram_rd_reset_busy  VRAM read port not ready; no reads issued while high
//   vram_addra/ena      VRAM read byte address / read enable
//   vram_douta          VRAM read data, valid 1 clk after vram_ena
//   m_tdata             pixel {R,G,B} = {byte 3p, 3p+1, 3p+2}
//   m_tvalid/m_tready   pixel stream handshake
//   m_tuser             start of frame (pixel 0,0)
//   m_tlast             end of line (x = H_PIXELS-1)
//   busy                frame in progress
//   frame_done          high in the transfer cycle of the last pixel of a frame
//
// Optional feature (macro SCANOUT_FRAME_CNT_EN):
//   adds output frame_count[15:0], counting frame_done pulses (wraps).
// -----------------------------------------------------------------------------
module vram_scanout_reader #(
    parameter int H_PIXELS   = 256,
    parameter int V_LINES    = 128,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  vram_rd_reset_busy,
    output logic [ADDR_WIDTH-1:0] vram_addra,
    output logic                  vram_ena,
    input  logic [7:0]            vram_douta,
    output logic [23:0]           m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  frame_done
`ifdef SCANOUT_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(3 * H_PIXELS * V_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_FETCH = 1'b1} state_t;

    state_t state_q, state_d;

    // Read-issue side
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;   // next address to issue
    logic [1:0]            issue_k_q, issue_k_d;   // byte index of next issue
    logic                  ena_q, ena_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Capture side
    logic                  cap_q, cap_d;           // read data present on vram_douta
    logic [1:0]            cap_k_q, cap_k_d;
    logic [XW-1:0]         cap_x_q, cap_x_d;
    logic [YW-1:0]         cap_y_q, cap_y_d;

    // Assembly register (holds a completed pixel when the output is full)
    logic [23:0]           asm_data_q, asm_data_d;
    logic                  asm_full_q, asm_full_d;
    logic                  asm_user_q, asm_user_d;
    logic                  asm_last_q, asm_last_d;
    logic                  asm_flast_q, asm_flast_d;

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic [23:0]           out_data_q, out_data_d;
    logic                  out_user_q, out_user_d;
    logic                  out_last_q, out_last_d;
    logic                  out_flast_q, out_flast_d;

    logic                  xfer_s;
    logic                  frame_end_s;
    logic                  asm_busy_s;
    logic                  space_ok_s;
    logic                  issue_s;
    logic                  pix_done_s;
    logic                  pix_user_s;
    logic                  pix_last_s;
    logic                  pix_flast_s;
    logic [23:0]           pix_data_s;
    logic                  out_free_s;
    logic                  busy_s;

    assign xfer_s      = out_valid_q & m_tready;
    assign frame_end_s = xfer_s & out_flast_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; leaving FETCH requires that no read of the next
    // frame has been issued (rd_addr_q back at 0), so a started frame always completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run && !vram_rd_reset_busy) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (frame_end_s && !run && (rd_addr_q == ADDR_ZERO)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            ST_FETCH: busy_s = 1'b1;
            ST_IDLE:  busy_s = 1'b0;
            default:  busy_s = 1'b0;
        endcase
    end

    // Read issue, byte capture and pixel buffering next-state logic
    always_comb begin
        // A new pixel may start only if it has somewhere to land: either the
        // output register is free, or the assembly register is idle.
        asm_busy_s = asm_full_q | (issue_k_q != 2'd0) | cap_q;
        space_ok_s = (issue_k_q != 2'd0) | ~(out_valid_q & asm_busy_s);
        // At address 0 a new frame begins, which only happens while run is high.
        issue_s    = ~vram_rd_reset_busy & space_ok_s
                   & ((rd_addr_q != ADDR_ZERO) | run)
                   & ((state_q == ST_FETCH) | run);

        rd_addr_d = rd_addr_q;
        issue_k_d = issue_k_q;
        addr_d    = addr_q;
        ena_d     = 1'b0;
        if (issue_s) begin
            ena_d  = 1'b1;
            addr_d = rd_addr_q;
            if (rd_addr_q == LAST_ADDR) begin
                rd_addr_d = ADDR_ZERO;
            end else begin
                rd_addr_d = rd_addr_q + ADDR_ONE;
            end
            if (issue_k_q == 2'd2) begin
                issue_k_d = 2'd0;
            end else begin
                issue_k_d = issue_k_q + 2'd1;
            end
        end else begin
            ena_d = 1'b0;
        end

        // Capture follows the issue order exactly, so the pixel position is
        // tracked here rather than carried alongside each read.
        cap_d      = ena_q;
        cap_k_d    = cap_k_q;
        cap_x_d    = cap_x_q;
        cap_y_d    = cap_y_q;
        asm_data_d = asm_data_q;
        pix_done_s = 1'b0;
        if (cap_q) begin
            asm_data_d = {asm_data_q[15:0], vram_douta};
            if (cap_k_q == 2'd2) begin
                cap_k_d    = 2'd0;
                pix_done_s = 1'b1;
                if (cap_x_q == X_LAST) begin
                    cap_x_d = XW'(0);
                    if (cap_y_q == Y_LAST) begin
                        cap_y_d = YW'(0);
                    end else begin
                        cap_y_d = cap_y_q + YW'(1);
                    end
                end else begin
                    cap_x_d = cap_x_q + XW'(1);
                end
            end else begin
                cap_k_d = cap_k_q + 2'd1;
            end
        end else begin
            cap_k_d = cap_k_q;
        end

        pix_data_s  = {asm_data_q[15:0], vram_douta};
        pix_user_s  = (cap_x_q == XW'(0)) & (cap_y_q == YW'(0));
        pix_last_s  = (cap_x_q == X_LAST);
        pix_flast_s = pix_last_s & (cap_y_q == Y_LAST);

        // Output register load: a held assembly pixel has priority; a pixel
        // completing this cycle goes straight to the output when it is free.
        out_free_s  = ~out_valid_q | xfer_s;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        out_flast_d = out_flast_q;
        asm_full_d  = asm_full_q;
        asm_user_d  = asm_user_q;
        asm_last_d  = asm_last_q;
        asm_flast_d = asm_flast_q;
        if (asm_full_q && out_free_s) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_data_q;
            out_user_d  = asm_user_q;
            out_last_d  = asm_last_q;
            out_flast_d = asm_flast_q;
            asm_full_d  = 1'b0;
        end else if (pix_done_s && out_free_s) begin
            out_valid_d = 1'b1;
            out_data_d  = pix_data_s;
            out_user_d  = pix_user_s;
            out_last_d  = pix_last_s;
            out_flast_d = pix_flast_s;
        end else if (pix_done_s) begin
            asm_full_d  = 1'b1;
            asm_user_d  = pix_user_s;
            asm_last_d  = pix_last_s;
            asm_flast_d = pix_flast_s;
        end else if (xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers; reset also drops any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q   <= ADDR_ZERO;
            issue_k_q   <= 2'd0;
            ena_q       <= 1'b0;
            addr_q      <= ADDR_ZERO;
            cap_q       <= 1'b0;
            cap_k_q     <= 2'd0;
            cap_x_q     <= XW'(0);
            cap_y_q     <= YW'(0);
            asm_data_q  <= 24'h000000;
            asm_full_q  <= 1'b0;
            asm_user_q  <= 1'b0;
            asm_last_q  <= 1'b0;
            asm_flast_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 24'h000000;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_flast_q <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            issue_k_q   <= issue_k_d;
            ena_q       <= ena_d;
            addr_q      <= addr_d;
            cap_q       <= cap_d;
            cap_k_q     <= cap_k_d;
            cap_x_q     <= cap_x_d;
            cap_y_q     <= cap_y_d;
            asm_data_q  <= asm_data_d;
            asm_full_q  <= asm_full_d;
            asm_user_q  <= asm_user_d;
            asm_last_q  <= asm_last_d;
            asm_flast_q <= asm_flast_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            out_flast_q <= out_flast_d;
        end
    end

    assign vram_addra = addr_q;
    assign vram_ena   = ena_q;
    assign m_tdata    = out_data_q;
    assign m_tvalid   = out_valid_q;
    assign m_tuser    = out_user_q;
    assign m_tlast    = out_last_q;
    assign busy       = busy_s;
    // Must coincide with the accepting handshake, hence derived from m_tready
    assign frame_done = frame_end_s;

`ifdef SCANOUT_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter next value; wraps naturally at 16 bits
    always_comb begin
        if (frame_end_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule
